rob_wb_arbiter: RTL and testbench

ROB_WB_ARBITER -- requirements
Module: rob_wb_arbiter

---
 rtl/rob_wb_arbiter_pkg.sv | 34 +++
 rtl/rob_wb_arbiter_rr_select.sv | 31 +++
 rtl/rob_wb_arbiter.sv | 117 +++++++++++
 tb/tb_rob_wb_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_wb_arbiter_pkg.sv
// Shared types for the ROB writeback arbiter: exception codes, the per-slot
// writeback payload and its reset value.
package rob_wb_arbiter_pkg;

  localparam int RobDepth = 32;
  localparam int RobIdW   = $clog2(RobDepth);
  localparam int ExpCodeW = 4;

  typedef enum logic [ExpCodeW-1:0] {
    EXP_NONE         = 4'd0,
    EXP_I_MISS_ALIGN = 4'd1,
    EXP_I_ACCESS     = 4'd2,
    EXP_ILLEGAL      = 4'd3,
    EXP_BREAK        = 4'd4,
    EXP_L_MISS_ALIGN = 4'd5,
    EXP_L_ACCESS     = 4'd6,
    EXP_S_MISS_ALIGN = 4'd7,
    EXP_S_ACCESS     = 4'd8,
    EXP_ECALL        = 4'd9
  } ExpCode_t;

  typedef struct packed {
    logic [RobIdW-1:0] rob_id;
    logic              exp_;
    ExpCode_t          exp_code;
    logic              pred_miss_;
    logic              jump_miss_;
  } WbReq_t;

  // Active-low flags idle high; id and code idle at zero.
  localparam WbReq_t WbReqRst = '{rob_id: '0, exp_: 1'b1, exp_code: EXP_NONE,
                                  pred_miss_: 1'b1, jump_miss_: 1'b1};

endpackage

// File: rtl/rob_wb_arbiter_rr_select.sv
// Rotating-priority selector: grants the first valid bit at or after ptr_i,
// wrapping at NREQ. A constant zero pointer gives fixed lowest-index priority.
module rr_select #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] vld_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   gnt_idx_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = PW'((int'(ptr_i) + off) % NREQ);
      if (!found && vld_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Collects completions from NREQ execution units into one registered ROB
// writeback port. Define WB_ARB_ROUND_ROBIN_EN for rotating priority.
module rob_wb_arbiter
  import rob_wb_arbiter_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int ROB_DEPTH = RobDepth,
  localparam int ROB       = $clog2(ROB_DEPTH),
  localparam int PW        = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     flush_,
  input  logic [NREQ-1:0]          req_e_,
  input  logic [NREQ*ROB-1:0]      req_rob_id,
  input  logic [NREQ-1:0]          req_exp_,
  input  logic [NREQ*ExpCodeW-1:0] req_exp_code,
  input  logic [NREQ-1:0]          req_pred_miss_,
  input  logic [NREQ-1:0]          req_jump_miss_,
  output logic [NREQ-1:0]          req_busy,
  output logic                     wb_e_,
  output logic [ROB-1:0]           wb_rob_id,
  output logic                     wb_exp_,
  output logic [ExpCodeW-1:0]      wb_exp_code,
  output logic                     wb_pred_miss_,
  output logic                     wb_jump_miss_
);

  logic [NREQ-1:0] vld_q, vld_d;
  WbReq_t          slot_q [NREQ];
  WbReq_t          slot_d [NREQ];
  WbReq_t          wb_q, wb_d;
  logic            wb_e_q, wb_e_d;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   ptr_sel;
  logic            gnt_any;

  rr_select #(.NREQ(NREQ)) u_rr_select (
    .vld_i     (vld_q),
    .ptr_i     (ptr_sel),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign gnt_any = |gnt;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Pointer is left alone on flush so fairness carries across the flush.
  always_comb begin
    ptr_d = ptr_q;
    if (flush_ && gnt_any)
      ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_sel = ptr_q;
`else
  assign ptr_sel = '0;
`endif

  always_comb begin
    vld_d  = vld_q;
    slot_d = slot_q;
    wb_d   = wb_q;
    wb_e_d = 1'b1;
    if (!flush_) begin
      vld_d = '0;
    end else begin
      if (gnt_any) begin
        wb_d   = slot_q[gnt_idx];
        wb_e_d = 1'b0;
      end
      vld_d = vld_q & ~gnt;
      // Load gated by the pre-grant valid: a slot granted now stays closed.
      for (int i = 0; i < NREQ; i++) begin
        if (!req_e_[i] && !vld_q[i]) begin
          vld_d[i]             = 1'b1;
          slot_d[i].rob_id     = RobIdW'(req_rob_id[i*ROB +: ROB]);
          slot_d[i].exp_       = req_exp_[i];
          slot_d[i].exp_code   = ExpCode_t'(req_exp_code[i*ExpCodeW +: ExpCodeW]);
          slot_d[i].pred_miss_ = req_pred_miss_[i];
          slot_d[i].jump_miss_ = req_jump_miss_[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      vld_q  <= '0;
      wb_e_q <= 1'b1;
      wb_q   <= WbReqRst;
      for (int i = 0; i < NREQ; i++) slot_q[i] <= WbReqRst;
    end else begin
      vld_q  <= vld_d;
      wb_e_q <= wb_e_d;
      wb_q   <= wb_d;
      for (int i = 0; i < NREQ; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign req_busy      = vld_q;
  assign wb_e_         = wb_e_q;
  assign wb_rob_id     = ROB'(wb_q.rob_id);
  assign wb_exp_       = wb_q.exp_;
  assign wb_exp_code   = wb_q.exp_code;
  assign wb_pred_miss_ = wb_q.pred_miss_;
  assign wb_jump_miss_ = wb_q.jump_miss_;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Scoreboard bench for rob_wb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_rob_wb_arbiter;
  import rob_wb_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int ROB  = $clog2(RobDepth);
  localparam int EW   = ExpCodeW;
  localparam int PL   = ROB + 1 + EW + 2;

  logic                 clk;
  logic                 reset_;
  logic                 flush_;
  logic [NREQ-1:0]      req_e_;
  logic [NREQ*ROB-1:0]  req_rob_id;
  logic [NREQ-1:0]      req_exp_;
  logic [NREQ*EW-1:0]   req_exp_code;
  logic [NREQ-1:0]      req_pred_miss_;
  logic [NREQ-1:0]      req_jump_miss_;
  logic [NREQ-1:0]      req_busy;
  logic                 wb_e_;
  logic [ROB-1:0]       wb_rob_id;
  logic                 wb_exp_;
  logic [EW-1:0]        wb_exp_code;
  logic                 wb_pred_miss_;
  logic                 wb_jump_miss_;

  rob_wb_arbiter #(.NREQ(NREQ), .ROB_DEPTH(RobDepth)) dut (
    .clk            (clk),
    .reset_         (reset_),
    .flush_         (flush_),
    .req_e_         (req_e_),
    .req_rob_id     (req_rob_id),
    .req_exp_       (req_exp_),
    .req_exp_code   (req_exp_code),
    .req_pred_miss_ (req_pred_miss_),
    .req_jump_miss_ (req_jump_miss_),
    .req_busy       (req_busy),
    .wb_e_          (wb_e_),
    .wb_rob_id      (wb_rob_id),
    .wb_exp_        (wb_exp_),
    .wb_exp_code    (wb_exp_code),
    .wb_pred_miss_  (wb_pred_miss_),
    .wb_jump_miss_  (wb_jump_miss_)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  localparam logic [PL-1:0] RstPl = {{ROB{1'b0}}, 1'b1, {EW{1'b0}}, 1'b1, 1'b1};

  // Reference model: slots as plain arrays, expected writebacks in a queue.
  bit            m_vld [NREQ];
  bit            m_old [NREQ];
  logic [PL-1:0] m_pl  [NREQ];
  int            m_ptr;
  int            m_w;
  logic [PL-1:0] m_last = RstPl;
  logic [PL-1:0] exp_q [$];
  int            seen_ids [$];
  int            exp_ids [$];
  logic [PL-1:0] last_pop;

  function automatic logic [PL-1:0] pl_of(int i);
    return {req_rob_id[i*ROB +: ROB], req_exp_[i], req_exp_code[i*EW +: EW],
            req_pred_miss_[i], req_jump_miss_[i]};
  endfunction

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NREQ; i++) m_vld[i] = 1'b0;
      m_ptr  = 0;
      m_last = RstPl;
      exp_q.delete();
    end else if (!flush_) begin
      for (int i = 0; i < NREQ; i++) m_vld[i] = 1'b0;
    end else begin
      m_old = m_vld;
      m_w   = -1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      for (int off = 0; off < NREQ; off++)
        if (m_w < 0 && m_old[(m_ptr + off) % NREQ]) m_w = (m_ptr + off) % NREQ;
`else
      for (int i = 0; i < NREQ; i++)
        if (m_w < 0 && m_old[i]) m_w = i;
`endif
      if (m_w >= 0) begin
        exp_q.push_back(m_pl[m_w]);
        m_last     = m_pl[m_w];
        m_vld[m_w] = 1'b0;
        m_ptr      = (m_w + 1) % NREQ;
      end
      for (int i = 0; i < NREQ; i++)
        if (!req_e_[i] && !m_old[i]) begin
          m_vld[i] = 1'b1;
          m_pl[i]  = pl_of(i);
        end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops an expected writeback whenever the DUT presents one.
  always @(negedge clk) begin
    logic [NREQ-1:0] mb;
    logic [PL-1:0]   dut_pl;
    for (int i = 0; i < NREQ; i++) mb[i] = m_vld[i];
    dut_pl = {wb_rob_id, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_};
    chk("req_busy", 32'(req_busy), 32'(mb));
    if (wb_e_ === 1'b0) begin
      seen_ids.push_back(int'(wb_rob_id));
      last_pop = dut_pl;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wb: got payload %0h expected no writeback at %0t", dut_pl, $time);
      end else begin
        logic [PL-1:0] e;
        e = exp_q.pop_front();
        if (dut_pl !== e) begin
          errors++;
          $display("FAIL wb_payload: got %0h expected %0h at %0t", dut_pl, e, $time);
        end
      end
    end else begin
      chk("wb_e_idle", 32'(wb_e_), 32'd1);
      chk("wb_hold", 32'(dut_pl), 32'(m_last));
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_wb: got wb_e_=1 expected writeback %0h at %0t", exp_q[0], $time);
        exp_q.delete();
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_e_         = '1;
    req_rob_id     = '0;
    req_exp_       = '1;
    req_exp_code   = '0;
    req_pred_miss_ = '1;
    req_jump_miss_ = '1;
  endtask

  task automatic set_req(input int i, input int id, input bit ex, input int code,
                         input bit pm, input bit jm);
    req_e_[i]                = 1'b0;
    req_rob_id[i*ROB +: ROB] = ROB'(id);
    req_exp_[i]              = ex;
    req_exp_code[i*EW +: EW] = EW'(code);
    req_pred_miss_[i]        = pm;
    req_jump_miss_[i]        = jm;
  endtask

  task automatic chk_ids(input string name, input int n);
    int bad;
    bad = -1;
    checks++;
    if (n == 0) begin
      if (seen_ids.size() != 0) bad = 0;
    end else begin
      if (seen_ids.size() < n) bad = seen_ids.size();
      else for (int i = 0; i < n; i++) if (bad < 0 && seen_ids[i] != exp_ids[i]) bad = i;
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: got %0d ids (first bad pos %0d, got %0d) expected %0d ids (want %0d)",
               name, seen_ids.size(), bad, (bad < seen_ids.size()) ? seen_ids[bad] : -1,
               n, (bad < n) ? exp_ids[bad] : -1);
    end
    seen_ids.delete();
    exp_ids.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset_ = 1'b0;
    @(negedge clk);
    #2 reset_ = 1'b1;
  endtask

  initial begin
    reset_ = 1'b1;
    flush_ = 1'b1;
    idle_inputs();
    #1 reset_ = 1'b0;
    #1;
    chk("rst_wb_e", 32'(wb_e_), 32'd1);
    chk("rst_busy", 32'(req_busy), 32'd0);
    chk("rst_flags", 32'({wb_exp_, wb_pred_miss_, wb_jump_miss_}), 32'd7);
    chk("rst_id_code", 32'({wb_rob_id, wb_exp_code}), 32'd0);
    tick(2);
    #2 reset_ = 1'b1;

    // Single request on requester 2.
    tick();
    seen_ids.delete();
    set_req(2, 5, 1, 0, 1, 1);
    tick();
    idle_inputs();
    chk("single_busy_set", 32'(req_busy[2]), 32'd1);
    chk("single_no_wb_yet", 32'(wb_e_), 32'd1);
    tick();
    chk("single_wb_e", 32'(wb_e_), 32'd0);
    chk("single_wb_id", 32'(wb_rob_id), 32'd5);
    chk("single_busy_clr", 32'(req_busy[2]), 32'd0);
    tick(3);
    exp_ids.push_back(5);
    chk_ids("single_ids", 1);

    // Contention from pointer 0.
    pulse_reset();
    tick();
    seen_ids.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, i, 1, 0, 1, 1);
    tick();
    idle_inputs();
    tick(6);
    for (int i = 0; i < NREQ; i++) exp_ids.push_back(i);
    chk_ids("contention_order", NREQ);

    // Fairness: three requesters re-request continuously.
    seen_ids.delete();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      for (int i = 0; i < 3; i++) if (!req_busy[i]) set_req(i, i, 1, 0, 1, 1);
      tick();
    end
    idle_inputs();
    tick(6);
`ifdef WB_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 6; k++) exp_ids.push_back(k % 3);
`else
    for (int k = 0; k < 6; k++) exp_ids.push_back(k % 2);
`endif
    chk_ids("fairness_order", 6);

    // Flush with two pending slots plus a same-edge request.
    seen_ids.delete();
    set_req(0, 9, 1, 0, 1, 1);
    set_req(3, 10, 1, 0, 1, 1);
    tick();
    idle_inputs();
    flush_ = 1'b0;
    set_req(1, 11, 1, 0, 1, 1);
    tick();
    flush_ = 1'b1;
    idle_inputs();
    chk("flush_busy", 32'(req_busy), 32'd0);
    chk("flush_wb_e", 32'(wb_e_), 32'd1);
    tick(4);
    chk_ids("flush_no_emit", 0);

    // Payload fields.
    seen_ids.delete();
    set_req(1, 7, 0, int'(EXP_I_MISS_ALIGN), 0, 1);
    tick();
    idle_inputs();
    tick(3);
    chk("payload_fields", 32'(last_pop),
        32'({5'd7, 1'b0, 4'(EXP_I_MISS_ALIGN), 1'b0, 1'b1}));
    exp_ids.push_back(7);
    chk_ids("payload_ids", 1);

    // Reset mid-burst with three valid slots.
    seen_ids.delete();
    for (int i = 0; i < 3; i++) set_req(i, 20 + i, 0, 3, 0, 0);
    tick();
    idle_inputs();
    chk("burst_busy", 32'(req_busy), 32'h7);
    #2 reset_ = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(req_busy), 32'd0);
    chk("mid_rst_wb_e", 32'(wb_e_), 32'd1);
    chk("mid_rst_flags", 32'({wb_exp_, wb_pred_miss_, wb_jump_miss_}), 32'd7);
    chk("mid_rst_id_code", 32'({wb_rob_id, wb_exp_code}), 32'd0);
    tick();
    #2 reset_ = 1'b1;
    tick(5);
    chk_ids("reset_no_emit", 0);

    // Random traffic, including drops while busy and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 1) == 0)
          set_req(i, int'($urandom_range(0, (1 << ROB) - 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      flush_ = ($urandom_range(0, 19) != 0);
      tick();
    end
    idle_inputs();
    flush_ = 1'b1;
    tick(10);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
